// File: rtl/riscv_ifu.sv
`default_nettype none
// ============================================================================
// Module   : riscv_ifu
// Brief    : Instruction fetch unit. Issues sequential word-address reads to a
//            pipelined instruction memory (at most two in flight), buffers the
//            returned instructions in a 2-entry {pc, instr} FIFO and presents
//            the head to decode over a valid/ready handshake. A redirect
//            flushes the FIFO, marks in-flight reads for discard and restarts
//            fetching at the new target.
// Revision : 1.0 - initial release
// ============================================================================
module riscv_ifu #(
    parameter logic [29:0] RESET_PC = 30'h0
) (
    input  logic        clk_i,
    input  logic        reset_ni,

    // redirect from the back end
    input  logic        flush_i,
    input  logic [29:0] target_i,

    // decode-side handshake
    output logic        valid_o,
    input  logic        ready_i,
    output logic [31:0] instr_o,
    output logic [29:0] pc_o,

    // instruction memory request channel
    output logic        imem_valid_o,
    input  logic        imem_ready_i,
    output logic [29:0] imem_addr_o,

    // instruction memory response channel (in order)
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i
);

    localparam int unsigned DEPTH = 2;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [29:0] fetch_pc_q;     // address of the next request
    logic [29:0] resp_pc_q;      // pc belonging to the next kept response
    logic [1:0]  outstanding_q;  // accepted but not yet returned reads
    logic [1:0]  discard_q;      // how many of those must be thrown away

    // FIFO as a two-stage shift structure: head feeds the outputs directly
    logic        head_vld_q;
    logic [29:0] head_pc_q;
    logic [31:0] head_instr_q;
    logic        tail_vld_q;
    logic [29:0] tail_pc_q;
    logic [31:0] tail_instr_q;

    // ------------------------------------------------------------------------
    // Combinational control
    // ------------------------------------------------------------------------
    logic [1:0]  count;
    logic        pop;
    logic [2:0]  credit_sum;
    logic        issue;
    logic        rsp;
    logic        drop;
    logic        push;
    logic [1:0]  outstanding_d;
    logic [1:0]  discard_d;
    logic [29:0] fetch_pc_d;
    logic [29:0] resp_pc_d;

    logic        head_vld_d;
    logic [29:0] head_pc_d;
    logic [31:0] head_instr_d;
    logic        tail_vld_d;
    logic [29:0] tail_pc_d;
    logic [31:0] tail_instr_d;

    assign count = {1'b0, head_vld_q} + {1'b0, tail_vld_q};
    assign pop   = head_vld_q & ready_i;

    // Every slot already held or promised to an in-flight read consumes a
    // credit; a pop this cycle frees one early so throughput stays at 1/cycle.
    assign credit_sum = {1'b0, count} + {1'b0, outstanding_q} - {2'b00, pop};

    // No request while in reset, during a redirect, or without a free credit.
    assign imem_valid_o = reset_ni & ~flush_i & (credit_sum < 3'(DEPTH));
    assign imem_addr_o  = fetch_pc_q;
    assign issue        = imem_valid_o & imem_ready_i;

    // A response with nothing outstanding is ignored outright.
    assign rsp  = imem_rvalid_i & (outstanding_q != 2'd0);
    assign drop = rsp & (flush_i | (discard_q != 2'd0));
    assign push = rsp & ~drop;

    assign valid_o = head_vld_q;
    assign pc_o    = head_pc_q;
    assign instr_o = head_instr_q;

    // Next-state for the address pointers and the in-flight bookkeeping.
    always_comb begin
        outstanding_d = outstanding_q + {1'b0, issue} - {1'b0, rsp};
        discard_d     = discard_q;
        fetch_pc_d    = fetch_pc_q;
        resp_pc_d     = resp_pc_q;

        if (flush_i) begin
            // issue is forced low here, so everything still in flight after
            // this cycle's response belongs to the old stream
            discard_d  = outstanding_d;
            fetch_pc_d = target_i;
            resp_pc_d  = target_i;
        end else begin
            if (rsp && (discard_q != 2'd0)) begin
                discard_d = discard_q - 2'd1;
            end
            if (issue) begin
                fetch_pc_d = fetch_pc_q + 30'd1;
            end
            if (push) begin
                resp_pc_d = resp_pc_q + 30'd1;
            end
        end
    end

    // Next-state for the FIFO: shift on pop, fill the first free slot on push.
    always_comb begin
        head_vld_d   = head_vld_q;
        head_pc_d    = head_pc_q;
        head_instr_d = head_instr_q;
        tail_vld_d   = tail_vld_q;
        tail_pc_d    = tail_pc_q;
        tail_instr_d = tail_instr_q;

        if (flush_i) begin
            head_vld_d = 1'b0;
            tail_vld_d = 1'b0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (!head_vld_q) begin
                        head_vld_d   = 1'b1;
                        head_pc_d    = resp_pc_q;
                        head_instr_d = imem_rdata_i;
                    end else begin
                        tail_vld_d   = 1'b1;
                        tail_pc_d    = resp_pc_q;
                        tail_instr_d = imem_rdata_i;
                    end
                end
                2'b01: begin
                    head_vld_d   = tail_vld_q;
                    head_pc_d    = tail_pc_q;
                    head_instr_d = tail_instr_q;
                    tail_vld_d   = 1'b0;
                end
                2'b11: begin
                    if (tail_vld_q) begin
                        head_pc_d    = tail_pc_q;
                        head_instr_d = tail_instr_q;
                        tail_pc_d    = resp_pc_q;
                        tail_instr_d = imem_rdata_i;
                    end else begin
                        head_pc_d    = resp_pc_q;
                        head_instr_d = imem_rdata_i;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Pointer and in-flight counter registers.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            fetch_pc_q    <= RESET_PC;
            resp_pc_q     <= RESET_PC;
            outstanding_q <= 2'd0;
            discard_q     <= 2'd0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            resp_pc_q     <= resp_pc_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
        end
    end

    // FIFO storage registers; the head drives the decode outputs.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            head_vld_q   <= 1'b0;
            head_pc_q    <= 30'd0;
            head_instr_q <= 32'd0;
            tail_vld_q   <= 1'b0;
            tail_pc_q    <= 30'd0;
            tail_instr_q <= 32'd0;
        end else begin
            head_vld_q   <= head_vld_d;
            head_pc_q    <= head_pc_d;
            head_instr_q <= head_instr_d;
            tail_vld_q   <= tail_vld_d;
            tail_pc_q    <= tail_pc_d;
            tail_instr_q <= tail_instr_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_riscv_ifu.sv
`default_nettype none
// ============================================================================
// Module   : tb_riscv_ifu
// Brief    : Self-checking bench for riscv_ifu. A behavioural pipelined memory
//            with variable latency answers requests; every accepted request
//            pushes its expected {pc, instr} into a scoreboard that is popped
//            and compared when decode takes an instruction.
// Revision : 1.0 - initial release
// ============================================================================
module tb_riscv_ifu;

    localparam logic [29:0] RESET_PC = 30'h100;

    logic        clk_i = 1'b0;
    logic        reset_ni = 1'b0;
    logic        flush_i = 1'b0;
    logic [29:0] target_i = 30'd0;
    logic        valid_o;
    logic        ready_i = 1'b0;
    logic [31:0] instr_o;
    logic [29:0] pc_o;
    logic        imem_valid_o;
    logic        imem_ready_i = 1'b0;
    logic [29:0] imem_addr_o;
    logic        imem_rvalid_i = 1'b0;
    logic [31:0] imem_rdata_i = 32'd0;

    riscv_ifu #(.RESET_PC(RESET_PC)) dut (
        .clk_i        (clk_i),
        .reset_ni     (reset_ni),
        .flush_i      (flush_i),
        .target_i     (target_i),
        .valid_o      (valid_o),
        .ready_i      (ready_i),
        .instr_o      (instr_o),
        .pc_o         (pc_o),
        .imem_valid_o (imem_valid_o),
        .imem_ready_i (imem_ready_i),
        .imem_addr_o  (imem_addr_o),
        .imem_rvalid_i(imem_rvalid_i),
        .imem_rdata_i (imem_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [29:0] pc;
        logic [31:0] instr;
    } sb_t;

    typedef struct {
        logic [29:0] addr;
        int          ret;
        bit          stale;
    } mq_t;

    sb_t         sbq[$];     // accepted, not yet popped (current stream only)
    mq_t         mq[$];      // memory reads in flight
    int          n_arr = 0;  // leading scoreboard entries whose data returned
    logic [29:0] exp_fetch = RESET_PC;
    int          cyc = 0;
    int          last_ret = 0;
    int          lat_lo = 1;
    int          lat_hi = 1;
    int          mrdy_pct = 100;
    int          n_vec = 0;
    int          n_err = 0;

    function automatic logic [31:0] mem_data(input logic [29:0] a);
        return {a, 2'b11} ^ 32'h5A00_0000;
    endfunction

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // One clock of stimulus, memory behaviour and checking.
    task automatic cycle(input bit rdy, input bit fl, input logic [29:0] tgt);
        int  stale;
        bit  pop;
        bit  rsp;
        bit  exp_iv;
        int  lat;
        sb_t e;
        mq_t m;
        @(posedge clk_i);
        #1;
        ready_i      = rdy;
        flush_i      = fl;
        target_i     = tgt;
        imem_ready_i = ($urandom_range(99) < mrdy_pct);
        rsp          = (mq.size() > 0) && (mq[0].ret == cyc);
        imem_rvalid_i = rsp;
        imem_rdata_i  = rsp ? mem_data(mq[0].addr) : 32'hDEAD_BEEF;
        #1;

        stale = 0;
        foreach (mq[i]) if (mq[i].stale) stale++;

        check("valid_o", 64'(valid_o), 64'(n_arr > 0));
        pop    = (n_arr > 0) && rdy;
        exp_iv = !fl && ((sbq.size() + stale - int'(pop)) < 2);
        check("imem_valid_o", 64'(imem_valid_o), 64'(exp_iv));

        if (pop) begin
            e = sbq.pop_front();
            n_arr--;
            check("pc_o", 64'(pc_o), 64'(e.pc));
            check("instr_o", 64'(instr_o), 64'(e.instr));
        end

        if (rsp) begin
            m = mq.pop_front();
            if (!m.stale && !fl) n_arr++;
        end

        if (imem_valid_o && imem_ready_i) begin
            check("imem_addr_o", 64'(imem_addr_o), 64'(exp_fetch));
            lat     = int'($urandom_range(lat_hi, lat_lo));
            m.addr  = imem_addr_o;
            m.ret   = (cyc + lat > last_ret) ? cyc + lat : last_ret + 1;
            m.stale = 1'b0;
            last_ret = m.ret;
            mq.push_back(m);
            e.pc    = exp_fetch;
            e.instr = mem_data(exp_fetch);
            sbq.push_back(e);
            exp_fetch = exp_fetch + 30'd1;
            check("outstanding_le2", 64'(mq.size() <= 2), 64'd1);
        end
        if (n_arr > 2) check("fifo_depth", 64'(n_arr), 64'd2);

        if (fl) begin
            sbq.delete();
            n_arr = 0;
            for (int i = 0; i < mq.size(); i++) begin
                m = mq[i];
                m.stale = 1'b1;
                mq[i] = m;
            end
            exp_fetch = tgt;
        end
        cyc++;
    endtask

    task automatic do_reset();
        @(posedge clk_i);
        #1;
        reset_ni      = 1'b0;
        imem_ready_i  = 1'b0;
        imem_rvalid_i = 1'b0;
        ready_i       = 1'b0;
        flush_i       = 1'b0;
        #1;
        check("rst_valid_o", 64'(valid_o), 64'd0);
        check("rst_pc_o", 64'(pc_o), 64'd0);
        check("rst_instr_o", 64'(instr_o), 64'd0);
        check("rst_imem_valid_o", 64'(imem_valid_o), 64'd0);
        check("rst_imem_addr_o", 64'(imem_addr_o), 64'(RESET_PC));
        sbq.delete();
        mq.delete();
        n_arr     = 0;
        exp_fetch = RESET_PC;
        @(posedge clk_i);
        #1;
        reset_ni = 1'b1;
        last_ret = cyc;
    endtask

    initial begin
        bit          fl;
        logic [29:0] tgt;

        do_reset();

        // sequential stream, 1-cycle memory, decode always ready
        lat_lo = 1; lat_hi = 1; mrdy_pct = 100;
        repeat (20) cycle(1'b1, 1'b0, 30'd0);

        // decode stall: two entries buffered, no further requests
        repeat (10) cycle(1'b0, 1'b0, 30'd0);
        check("stall_imem_valid", 64'(imem_valid_o), 64'd0);
        check("stall_valid_o", 64'(valid_o), 64'd1);
        repeat (10) cycle(1'b1, 1'b0, 30'd0);

        // redirect coinciding with a response and a pop
        cycle(1'b1, 1'b1, 30'h200);
        repeat (8) cycle(1'b1, 1'b0, 30'd0);

        // 3-cycle memory, redirect with two reads in flight
        lat_lo = 3; lat_hi = 3;
        repeat (12) cycle(1'b1, 1'b0, 30'd0);
        cycle(1'b1, 1'b1, 30'h40);
        repeat (15) cycle(1'b1, 1'b0, 30'd0);

        // address wrap
        lat_lo = 1; lat_hi = 1;
        cycle(1'b1, 1'b1, 30'h3FFF_FFFF);
        repeat (8) cycle(1'b1, 1'b0, 30'd0);

        // reset in the middle of a stream
        do_reset();
        repeat (10) cycle(1'b1, 1'b0, 30'd0);

        // random traffic
        lat_lo = 1; lat_hi = 4; mrdy_pct = 70;
        repeat (2000) begin
            fl  = ($urandom_range(99) < 3);
            tgt = ($urandom_range(3) == 0) ? 30'h3FFF_FFFE : 30'($urandom);
            cycle(($urandom_range(99) < 70), fl, tgt);
        end
        repeat (10) cycle(1'b1, 1'b0, 30'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
